mem_access_unit: RTL and testbench

//   Memory-access stage directly downstream of the execute unit. Takes the decoded opcode and operands
//   for one instruction, issues load/store traffic on a 64-bit aligned data bus (splitting accesses that

---
 rtl/mem_access_unit_pkg.sv | 76 +++++++
 rtl/mem_lane_align.sv | 48 ++++
 rtl/mem_access_unit.sv | 177 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-access stage.
//   - FSM state encoding
//   - access size codes
//   - instruction opcodes seen by this stage
//   - opcode decode helpers (load/store/size/signedness)
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBeat1 = 2'd1,
    StBeat2 = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [7:0] INST_ADDI = 8'h01;
  localparam logic [7:0] INST_LB   = 8'h20;
  localparam logic [7:0] INST_LH   = 8'h21;
  localparam logic [7:0] INST_LW   = 8'h22;
  localparam logic [7:0] INST_LD   = 8'h23;
  localparam logic [7:0] INST_LBU  = 8'h24;
  localparam logic [7:0] INST_LHU  = 8'h25;
  localparam logic [7:0] INST_LWU  = 8'h26;
  localparam logic [7:0] INST_SB   = 8'h28;
  localparam logic [7:0] INST_SH   = 8'h29;
  localparam logic [7:0] INST_SW   = 8'h2A;
  localparam logic [7:0] INST_SD   = 8'h2B;

  function automatic logic op_is_load(input logic [7:0] op);
    logic r;
    case (op)
      INST_LB, INST_LH, INST_LW, INST_LD, INST_LBU, INST_LHU, INST_LWU: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_is_store(input logic [7:0] op);
    logic r;
    case (op)
      INST_SB, INST_SH, INST_SW, INST_SD: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_is_mem(input logic [7:0] op);
    return op_is_load(op) | op_is_store(op);
  endfunction

  function automatic logic [1:0] op_size(input logic [7:0] op);
    logic [1:0] r;
    case (op)
      INST_LB, INST_LBU, INST_SB: r = SZ_B;
      INST_LH, INST_LHU, INST_SH: r = SZ_H;
      INST_LW, INST_LWU, INST_SW: r = SZ_W;
      default:                    r = SZ_D;
    endcase
    return r;
  endfunction

  // Only the explicitly unsigned loads zero-extend.
  function automatic logic op_signed(input logic [7:0] op);
    logic r;
    case (op)
      INST_LBU, INST_LHU, INST_LWU: r = 1'b0;
      default:                      r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment for a possibly two-beat access.
//   i_size     access size code (SZ_*)
//   i_off      byte offset within the 8-byte word
//   i_signed   sign-extend load result
//   i_wdata    store data, right-aligned
//   i_rdata_lo first-beat read data
//   i_rdata_hi second-beat read data (0 when single beat)
//   o_strb     16-bit strobe across both beats
//   o_wdata    128-bit shifted store data across both beats
//   o_load     extracted and extended load result
//   o_crosses  access spans an 8-byte boundary
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]   i_size,
  input  logic [2:0]   i_off,
  input  logic         i_signed,
  input  logic [63:0]  i_wdata,
  input  logic [63:0]  i_rdata_lo,
  input  logic [63:0]  i_rdata_hi,
  output logic [15:0]  o_strb,
  output logic [127:0] o_wdata,
  output logic [63:0]  o_load,
  output logic         o_crosses
);

  logic [3:0]  w_nbytes;
  logic [6:0]  w_shamt;
  logic [63:0] w_raw;

  assign w_nbytes  = 4'd1 << i_size;
  assign w_shamt   = {i_off, 3'b000};
  assign o_crosses = ({1'b0, i_off} + w_nbytes) > 4'd8;
  assign o_strb    = ((16'd1 << w_nbytes) - 16'd1) << i_off;
  assign o_wdata   = {64'd0, i_wdata} << w_shamt;
  assign w_raw     = 64'({i_rdata_hi, i_rdata_lo} >> w_shamt);

  always_comb begin
    o_load = w_raw;
    case (i_size)
      SZ_B:    o_load = i_signed ? {{56{w_raw[7]}}, w_raw[7:0]}   : {56'd0, w_raw[7:0]};
      SZ_H:    o_load = i_signed ? {{48{w_raw[15]}}, w_raw[15:0]} : {48'd0, w_raw[15:0]};
      SZ_W:    o_load = i_signed ? {{32{w_raw[31]}}, w_raw[31:0]} : {32'd0, w_raw[31:0]};
      default: o_load = w_raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: latches one instruction from execute, performs a one- or
// two-beat aligned data-bus access for loads/stores, and presents rd write data.
//   clk, rst           clock, asynchronous active-low reset
//   ena / req / ack    stage handshake (ena sampled in IDLE, req held until ack)
//   i_inst_opcode      opcode; i_op1 + i_op2 = address; i_op3 = store data
//   i_rd_wdata         execute result for non-memory ops
//   i_skip_cmt         execute skip-commit flag
//   o_rd_wdata         final rd data, o_skip_cmt = skip flag OR MMIO hit
//   o_dbus_*           data bus request side; i_dbus_ack/i_dbus_rdata response
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter logic [63:0] MMIO_BASE = 64'h0000_0000_0200_0000,
  parameter logic [63:0] MMIO_MASK = 64'hFFFF_FFFF_FF00_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        ack,
  output logic        req,
  input  logic [7:0]  i_inst_opcode,
  input  logic [63:0] i_op1,
  input  logic [63:0] i_op2,
  input  logic [63:0] i_op3,
  input  logic [63:0] i_rd_wdata,
  input  logic        i_skip_cmt,
  output logic [63:0] o_rd_wdata,
  output logic        o_skip_cmt,
  output logic        o_dbus_req,
  output logic        o_dbus_we,
  output logic [63:0] o_dbus_addr,
  output logic [63:0] o_dbus_wdata,
  output logic [7:0]  o_dbus_wstrb,
  input  logic        i_dbus_ack,
  input  logic [63:0] i_dbus_rdata
);

  state_e      r_state, w_state_nxt;
  logic [7:0]  r_opcode, w_opcode_nxt;
  logic [63:0] r_addr, w_addr_nxt;
  logic [63:0] r_op3, w_op3_nxt;
  logic        r_skip_in, w_skip_in_nxt;
  logic [63:0] r_beat1_rdata, w_beat1_rdata_nxt;
  logic [63:0] r_rd_wdata, w_rd_wdata_nxt;
  logic        r_skip_cmt, w_skip_cmt_nxt;

  logic         w_busy;
  logic         w_beat2;
  logic         w_mmio_hit;
  logic [63:0]  w_base_addr;
  logic [63:0]  w_rdata_lo;
  logic [63:0]  w_rdata_hi;
  logic [15:0]  w_strb;
  logic [127:0] w_wdata;
  logic [63:0]  w_load;
  logic         w_crosses;

  assign w_beat2     = (r_state == StBeat2);
  assign w_busy      = (r_state == StBeat1) || w_beat2;
  assign w_base_addr = {r_addr[63:3], 3'b000};
  assign w_mmio_hit  = ((r_addr & MMIO_MASK) == MMIO_BASE);

  // First-beat data is parked so both halves are presented together on the final ack.
  assign w_rdata_lo = w_beat2 ? r_beat1_rdata : i_dbus_rdata;
  assign w_rdata_hi = w_beat2 ? i_dbus_rdata  : 64'd0;

  mem_lane_align u_align (
    .i_size     (op_size(r_opcode)),
    .i_off      (r_addr[2:0]),
    .i_signed   (op_signed(r_opcode)),
    .i_wdata    (r_op3),
    .i_rdata_lo (w_rdata_lo),
    .i_rdata_hi (w_rdata_hi),
    .o_strb     (w_strb),
    .o_wdata    (w_wdata),
    .o_load     (w_load),
    .o_crosses  (w_crosses)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= StIdle;
      r_opcode      <= 8'd0;
      r_addr        <= 64'd0;
      r_op3         <= 64'd0;
      r_skip_in     <= 1'b0;
      r_beat1_rdata <= 64'd0;
      r_rd_wdata    <= 64'd0;
      r_skip_cmt    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_opcode      <= w_opcode_nxt;
      r_addr        <= w_addr_nxt;
      r_op3         <= w_op3_nxt;
      r_skip_in     <= w_skip_in_nxt;
      r_beat1_rdata <= w_beat1_rdata_nxt;
      r_rd_wdata    <= w_rd_wdata_nxt;
      r_skip_cmt    <= w_skip_cmt_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_opcode_nxt      = r_opcode;
    w_addr_nxt        = r_addr;
    w_op3_nxt         = r_op3;
    w_skip_in_nxt     = r_skip_in;
    w_beat1_rdata_nxt = r_beat1_rdata;
    w_rd_wdata_nxt    = r_rd_wdata;
    w_skip_cmt_nxt    = r_skip_cmt;

    case (r_state)
      StIdle: begin
        if (ena) begin
          w_opcode_nxt  = i_inst_opcode;
          w_addr_nxt    = i_op1 + i_op2;
          w_op3_nxt     = i_op3;
          w_skip_in_nxt = i_skip_cmt;
          if (op_is_mem(i_inst_opcode)) begin
            w_state_nxt = StBeat1;
          end else begin
            w_state_nxt    = StDone;
            w_rd_wdata_nxt = i_rd_wdata;
            w_skip_cmt_nxt = i_skip_cmt;
          end
        end
      end
      StBeat1, StBeat2: begin
        if (i_dbus_ack) begin
          if ((r_state == StBeat1) && w_crosses) begin
            w_state_nxt       = StBeat2;
            w_beat1_rdata_nxt = i_dbus_rdata;
          end else begin
            w_state_nxt    = StDone;
            w_rd_wdata_nxt = op_is_store(r_opcode) ? 64'd0 : w_load;
            w_skip_cmt_nxt = r_skip_in | w_mmio_hit;
          end
        end
      end
      StDone: begin
        if (ack) begin
          w_state_nxt    = StIdle;
          w_rd_wdata_nxt = 64'd0;
          w_skip_cmt_nxt = 1'b0;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Bus outputs derive only from registers, so they hold still for the whole beat
  // and collapse immediately when reset forces the state back to IDLE.
  always_comb begin
    o_dbus_req   = w_busy;
    o_dbus_we    = 1'b0;
    o_dbus_addr  = 64'd0;
    o_dbus_wdata = 64'd0;
    o_dbus_wstrb = 8'd0;
    if (w_busy) begin
      o_dbus_we = op_is_store(r_opcode);
      if (w_beat2) begin
        o_dbus_addr  = w_base_addr + 64'd8;
        o_dbus_wdata = w_wdata[127:64];
        o_dbus_wstrb = w_strb[15:8];
      end else begin
        o_dbus_addr  = w_base_addr;
        o_dbus_wdata = w_wdata[63:0];
        o_dbus_wstrb = w_strb[7:0];
      end
    end
  end

  assign req        = (r_state == StDone);
  assign o_rd_wdata = r_rd_wdata;
  assign o_skip_cmt = r_skip_cmt;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic        ack = 1'b0;
  logic        req;
  logic [7:0]  i_inst_opcode = 8'd0;
  logic [63:0] i_op1 = 64'd0;
  logic [63:0] i_op2 = 64'd0;
  logic [63:0] i_op3 = 64'd0;
  logic [63:0] i_rd_wdata = 64'd0;
  logic        i_skip_cmt = 1'b0;
  logic [63:0] o_rd_wdata;
  logic        o_skip_cmt;
  logic        o_dbus_req;
  logic        o_dbus_we;
  logic [63:0] o_dbus_addr;
  logic [63:0] o_dbus_wdata;
  logic [7:0]  o_dbus_wstrb;
  logic        i_dbus_ack = 1'b0;
  logic [63:0] i_dbus_rdata = 64'd0;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .ack          (ack),
    .req          (req),
    .i_inst_opcode(i_inst_opcode),
    .i_op1        (i_op1),
    .i_op2        (i_op2),
    .i_op3        (i_op3),
    .i_rd_wdata   (i_rd_wdata),
    .i_skip_cmt   (i_skip_cmt),
    .o_rd_wdata   (o_rd_wdata),
    .o_skip_cmt   (o_skip_cmt),
    .o_dbus_req   (o_dbus_req),
    .o_dbus_we    (o_dbus_we),
    .o_dbus_addr  (o_dbus_addr),
    .o_dbus_wdata (o_dbus_wdata),
    .o_dbus_wstrb (o_dbus_wstrb),
    .i_dbus_ack   (i_dbus_ack),
    .i_dbus_rdata (i_dbus_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Presents one instruction for a single cycle; returns at the negedge after it is latched.
  task automatic issue(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c, input logic [63:0] rdw, input logic sk);
    i_inst_opcode = op;
    i_op1 = a;
    i_op2 = b;
    i_op3 = c;
    i_rd_wdata = rdw;
    i_skip_cmt = sk;
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
  endtask

  // Waits (bounded) for a bus request, checks it, holds it for 'waits' cycles, then acks.
  task automatic bus_beat(input string tag, input logic [63:0] ea, input logic ewe,
                          input logic [7:0] es, input logic [63:0] ewd,
                          input logic [63:0] rd, input int waits);
    int n = 0;
    while (!o_dbus_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_dreq"}, {63'd0, o_dbus_req}, 64'd1);
    check({tag, "_addr"}, o_dbus_addr, ea);
    check({tag, "_we"}, {63'd0, o_dbus_we}, {63'd0, ewe});
    check({tag, "_strb"}, {56'd0, o_dbus_wstrb}, {56'd0, es});
    check({tag, "_wdata"}, o_dbus_wdata, ewd);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      check({tag, "_hold_dreq"}, {63'd0, o_dbus_req}, 64'd1);
      check({tag, "_hold_addr"}, o_dbus_addr, ea);
      check({tag, "_hold_req"}, {63'd0, req}, 64'd0);
    end
    i_dbus_ack = 1'b1;
    i_dbus_rdata = rd;
    @(negedge clk);
    i_dbus_ack = 1'b0;
    i_dbus_rdata = 64'd0;
  endtask

  // Checks the result phase, then acks it and checks the outputs clear.
  task automatic finish(input string tag, input logic [63:0] erd, input logic esk);
    check({tag, "_req"}, {63'd0, req}, 64'd1);
    check({tag, "_rd"}, o_rd_wdata, erd);
    check({tag, "_skip"}, {63'd0, o_skip_cmt}, {63'd0, esk});
    check({tag, "_nodreq"}, {63'd0, o_dbus_req}, 64'd0);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check({tag, "_req_clr"}, {63'd0, req}, 64'd0);
    check({tag, "_rd_clr"}, o_rd_wdata, 64'd0);
  endtask

  initial begin
    #12;
    check("rst_req", {63'd0, req}, 64'd0);
    check("rst_dreq", {63'd0, o_dbus_req}, 64'd0);
    check("rst_rd", o_rd_wdata, 64'd0);
    check("rst_skip", {63'd0, o_skip_cmt}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Non-memory pass-through.
    issue(INST_ADDI, 64'd0, 64'd0, 64'd0, 64'h1234, 1'b0);
    finish("addi", 64'h1234, 1'b0);

    // LW, sign extension; LWU via negative offset, zero extension.
    issue(INST_LW, 64'h8000_0000, 64'd4, 64'd0, 64'd0, 1'b0);
    bus_beat("lw", 64'h8000_0000, 1'b0, 8'hF0, 64'd0, 64'h8765_4321_DEAD_BEEF, 0);
    finish("lw", 64'hFFFF_FFFF_8765_4321, 1'b0);
    issue(INST_LWU, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0, 1'b0);
    bus_beat("lwu", 64'h8000_0000, 1'b0, 8'hF0, 64'd0, 64'h8765_4321_DEAD_BEEF, 0);
    finish("lwu", 64'h0000_0000_8765_4321, 1'b0);

    // Crossing SH.
    issue(INST_SH, 64'h8000_0007, 64'd0, 64'h0000_0000_0000_BEEF, 64'h5555, 1'b0);
    bus_beat("sh_b1", 64'h8000_0000, 1'b1, 8'h80, 64'hEF00_0000_0000_0000, 64'd0, 1);
    bus_beat("sh_b2", 64'h8000_0008, 1'b1, 8'h01, 64'h0000_0000_0000_00BE, 64'd0, 0);
    finish("sh", 64'd0, 1'b0);

    // Crossing LH with sign extension.
    issue(INST_LH, 64'h8000_0007, 64'd0, 64'd0, 64'd0, 1'b0);
    bus_beat("lh_b1", 64'h8000_0000, 1'b0, 8'h80, 64'd0, 64'h8800_0000_0000_0000, 0);
    bus_beat("lh_b2", 64'h8000_0008, 1'b0, 8'h01, 64'd0, 64'h0000_0000_0000_00FF, 0);
    finish("lh", 64'hFFFF_FFFF_FFFF_FF88, 1'b0);

    // Crossing LW at the top of the address space; second beat wraps to 0.
    issue(INST_LW, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 64'd0, 64'd0, 1'b0);
    bus_beat("wrap_b1", 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 8'hE0, 64'd0,
             64'h4433_2211_0000_0000, 0);
    bus_beat("wrap_b2", 64'h0000_0000_0000_0000, 1'b0, 8'h01, 64'd0,
             64'h0000_0000_8877_6655, 0);
    finish("wrap", 64'h0000_0000_5544_3322, 1'b0);

    // MMIO LD with a slow bus.
    issue(INST_LD, 64'h0200_BFF0, 64'd8, 64'd0, 64'd0, 1'b0);
    bus_beat("mmio", 64'h0200_BFF8, 1'b0, 8'hFF, 64'd0, 64'h1122_3344_5566_7788, 5);
    finish("mmio", 64'h1122_3344_5566_7788, 1'b1);

    // Execute skip flag on a plain op.
    issue(INST_ADDI, 64'd0, 64'd0, 64'd0, 64'hABCD, 1'b1);
    finish("skip_in", 64'hABCD, 1'b1);

    // Asynchronous reset during BEAT1.
    issue(INST_LD, 64'h8000_0000, 64'd0, 64'd0, 64'd0, 1'b0);
    check("mid_dreq", {63'd0, o_dbus_req}, 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_dreq", {63'd0, o_dbus_req}, 64'd0);
    check("mid_rst_req", {63'd0, req}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(INST_ADDI, 64'd0, 64'd0, 64'd0, 64'h0055, 1'b0);
    finish("post_rst", 64'h0055, 1'b0);

    // ena held high through DONE; ack+ena together must not relatch.
    i_inst_opcode = INST_ADDI;
    i_rd_wdata = 64'h1111;
    ena = 1'b1;
    @(negedge clk);
    check("hold_req", {63'd0, req}, 64'd1);
    i_rd_wdata = 64'h3333;
    @(negedge clk);
    check("hold_rd", o_rd_wdata, 64'h1111);
    i_rd_wdata = 64'h2222;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("hold_idle_req", {63'd0, req}, 64'd0);
    @(negedge clk);
    ena = 1'b0;
    check("hold_new_req", {63'd0, req}, 64'd1);
    check("hold_new_rd", o_rd_wdata, 64'h2222);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
